// File: rtl/dma_cmd_queue_pkg.sv
// dma_pkg: shared types and constants for the DMA command queue.
//   dma_cmd_t      - packed command {src_start_addr, dst_start_addr, xfer_length},
//                    source address in the MSBs, length in the LSBs.
//   cmdq_status_t  - queue status bundle as exposed to the dispatcher CSRs.
//   CMDQ_DEPTH_DEFAULT - default queue depth in entries.
package dma_pkg;

    localparam int SRC_ADDR_WIDTH_DEFAULT    = 48;
    localparam int DST_ADDR_WIDTH_DEFAULT    = 48;
    localparam int XFER_LENGTH_WIDTH_DEFAULT = 40;
    localparam int CMDQ_DEPTH_DEFAULT        = 128;
    localparam int CMDQ_USEDW_WIDTH_DEFAULT  = $clog2(CMDQ_DEPTH_DEFAULT) + 1;

    typedef struct packed {
        logic [SRC_ADDR_WIDTH_DEFAULT-1:0]    src_start_addr;
        logic [DST_ADDR_WIDTH_DEFAULT-1:0]    dst_start_addr;
        logic [XFER_LENGTH_WIDTH_DEFAULT-1:0] xfer_length;
    } dma_cmd_t;

    typedef struct packed {
        logic                                empty;
        logic                                full;
        logic                                underflow;
        logic                                overflow;
        logic [CMDQ_USEDW_WIDTH_DEFAULT-1:0] usedw;
    } cmdq_status_t;

endpackage

// File: rtl/dma_cmd_queue_if.sv
// dma_cmd_queue_if: command handshake between dispatcher/controller and queue.
//   new_cmd   - one-cycle push strobe from the dispatcher
//   cmd_in    - packed command to push
//   cmd_out   - head entry (show-ahead)
//   cmd_valid - head entry present
//   cmd_pop   - controller consumes the head
// Modports: master (dispatcher/controller side), slave (queue side).
interface dma_cmd_queue_if #(
    parameter int CMD_WIDTH = 136
) ();

    logic                 new_cmd;
    logic [CMD_WIDTH-1:0] cmd_in;
    logic [CMD_WIDTH-1:0] cmd_out;
    logic                 cmd_valid;
    logic                 cmd_pop;

    modport master (
        output new_cmd,
        output cmd_in,
        output cmd_pop,
        input  cmd_out,
        input  cmd_valid
    );

    modport slave (
        input  new_cmd,
        input  cmd_in,
        input  cmd_pop,
        output cmd_out,
        output cmd_valid
    );

endinterface

// File: rtl/dma_cmd_queue_storage.sv
// dma_cmdq_storage: simple-dual-port command array, registered write and
// combinational read, shaped for MLAB/distributed RAM inference. Not reset.
//   clk     - write clock
//   wr_en   - write strobe
//   wr_addr - write index
//   wr_data - write data
//   rd_addr - read index
//   rd_data - combinational read data
module dma_cmdq_storage #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 136,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Registered write port; no reset so the array maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/dma_cmd_queue.sv
// dma_cmd_queue: show-ahead command FIFO between DMA dispatcher and transfer
// controller, with CSR status (empty, full, sticky underflow/overflow, usedw)
// and a saturating count of discarded zero-length commands.
// Ports:
//   clk, resetn (async active-low), sclr (sync clear, beats push/pop)
//   cmd_if               - slave side of dma_cmd_queue_if (push/pop handshake)
//   cmdq_empty/full      - occupancy == 0 / == CMDQ_DEPTH
//   cmdq_underflow       - sticky, pop while empty
//   cmdq_overflow        - sticky, push while full without same-cycle pop
//   cmdq_usedw           - occupancy 0..CMDQ_DEPTH
//   cmdq_zero_len_drops  - saturating zero-length discard count
// Optional: define DMA_CMDQ_HIGHWATER_EN to add cmdq_usedw_highwater, the
// peak usedw since reset/sclr (lags usedw by one cycle).
module dma_cmd_queue
    import dma_pkg::*;
#(
    parameter int SRC_ADDR_WIDTH    = 48,
    parameter int DST_ADDR_WIDTH    = 48,
    parameter int XFER_LENGTH_WIDTH = 40,
    parameter int CMDQ_DEPTH        = CMDQ_DEPTH_DEFAULT,
    parameter int CMDQ_USEDW_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        sclr,
    dma_cmd_queue_if.slave              cmd_if,
    output logic                        cmdq_empty,
    output logic                        cmdq_full,
    output logic                        cmdq_underflow,
    output logic                        cmdq_overflow,
    output logic [CMDQ_USEDW_WIDTH-1:0] cmdq_usedw,
    output logic [15:0]                 cmdq_zero_len_drops
`ifdef DMA_CMDQ_HIGHWATER_EN
    ,
    output logic [CMDQ_USEDW_WIDTH-1:0] cmdq_usedw_highwater
`endif
);

    localparam int CMD_WIDTH = SRC_ADDR_WIDTH + DST_ADDR_WIDTH + XFER_LENGTH_WIDTH;
    localparam int AW        = $clog2(CMDQ_DEPTH);
    localparam int UW        = CMDQ_USEDW_WIDTH;

    if (CMDQ_USEDW_WIDTH != $clog2(CMDQ_DEPTH) + 1) begin : g_usedw_width_chk
        $error("CMDQ_USEDW_WIDTH must equal $clog2(CMDQ_DEPTH)+1");
    end
    if ((CMDQ_DEPTH < 2) || ((CMDQ_DEPTH & (CMDQ_DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("CMDQ_DEPTH must be a power of two and >= 2");
    end

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [UW-1:0] usedw_r;
    logic          empty_r;
    logic          full_r;
    logic          valid_r;
    logic          underflow_r;
    logic          overflow_r;
    logic [15:0]   zero_drops_r;

    logic          len_zero_s;
    logic          push_req_s;
    logic          pop_ok_s;
    logic          push_ok_s;
    logic [UW-1:0] usedw_nxt_s;

    assign len_zero_s = (cmd_if.cmd_in[XFER_LENGTH_WIDTH-1:0] == {XFER_LENGTH_WIDTH{1'b0}});
    assign push_req_s = cmd_if.new_cmd & ~len_zero_s;
    assign pop_ok_s   = cmd_if.cmd_pop & valid_r;
    // A full queue still accepts a push when the head leaves in the same
    // cycle: the write lands on the slot being vacated.
    assign push_ok_s  = push_req_s & (~full_r | pop_ok_s);

    // Next occupancy from accepted push/pop.
    always_comb begin
        usedw_nxt_s = usedw_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   usedw_nxt_s = usedw_r + UW'(1);
            2'b01:   usedw_nxt_s = usedw_r - UW'(1);
            default: usedw_nxt_s = usedw_r;
        endcase
    end

    // Pointers, occupancy and derived status flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            usedw_r  <= UW'(0);
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else if (sclr) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            usedw_r  <= UW'(0);
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            usedw_r <= usedw_nxt_s;
            empty_r <= (usedw_nxt_s == UW'(0));
            full_r  <= (usedw_nxt_s == UW'(CMDQ_DEPTH));
            valid_r <= (usedw_nxt_s != UW'(0));
        end
    end

    // Sticky error flags and saturating zero-length drop counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            underflow_r  <= 1'b0;
            overflow_r   <= 1'b0;
            zero_drops_r <= 16'h0000;
        end else if (sclr) begin
            underflow_r  <= 1'b0;
            overflow_r   <= 1'b0;
            zero_drops_r <= 16'h0000;
        end else begin
            if (cmd_if.cmd_pop && !valid_r) begin
                underflow_r <= 1'b1;
            end
            if (push_req_s && full_r && !pop_ok_s) begin
                overflow_r <= 1'b1;
            end
            if (cmd_if.new_cmd && len_zero_s && (zero_drops_r != 16'hFFFF)) begin
                zero_drops_r <= zero_drops_r + 16'h0001;
            end
        end
    end

`ifdef DMA_CMDQ_HIGHWATER_EN
    logic [UW-1:0] highwater_r;

    // Peak occupancy, compared against the registered usedw.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            highwater_r <= UW'(0);
        end else if (sclr) begin
            highwater_r <= UW'(0);
        end else if (usedw_r > highwater_r) begin
            highwater_r <= usedw_r;
        end else begin
            highwater_r <= highwater_r;
        end
    end

    assign cmdq_usedw_highwater = highwater_r;
`endif

    dma_cmdq_storage #(
        .DEPTH (CMDQ_DEPTH),
        .WIDTH (CMD_WIDTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push_ok_s & ~sclr),
        .wr_addr (wr_ptr_r),
        .wr_data (cmd_if.cmd_in),
        .rd_addr (rd_ptr_r),
        .rd_data (cmd_if.cmd_out)
    );

    assign cmd_if.cmd_valid    = valid_r;
    assign cmdq_empty          = empty_r;
    assign cmdq_full           = full_r;
    assign cmdq_underflow      = underflow_r;
    assign cmdq_overflow       = overflow_r;
    assign cmdq_usedw          = usedw_r;
    assign cmdq_zero_len_drops = zero_drops_r;

endmodule

// File: tb/tb_dma_cmd_queue.sv
// tb_dma_cmd_queue: directed scenarios plus randomized traffic against a
// queue-based reference model of the command FIFO.
module tb_dma_cmd_queue;
    import dma_pkg::*;

    localparam int DEPTH = CMDQ_DEPTH_DEFAULT;
    localparam int UW    = $clog2(DEPTH) + 1;
    localparam int CW    = $bits(dma_cmd_t);

    logic          clk = 1'b0;
    logic          resetn;
    logic          sclr;
    logic          cmdq_empty;
    logic          cmdq_full;
    logic          cmdq_underflow;
    logic          cmdq_overflow;
    logic [UW-1:0] cmdq_usedw;
    logic [15:0]   cmdq_zero_len_drops;
`ifdef DMA_CMDQ_HIGHWATER_EN
    logic [UW-1:0] cmdq_usedw_highwater;
`endif

    dma_cmd_queue_if #(.CMD_WIDTH(CW)) cmd_if ();

    dma_cmd_queue #(
        .CMDQ_DEPTH       (DEPTH),
        .CMDQ_USEDW_WIDTH (UW)
    ) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .sclr                (sclr),
        .cmd_if              (cmd_if),
        .cmdq_empty          (cmdq_empty),
        .cmdq_full           (cmdq_full),
        .cmdq_underflow      (cmdq_underflow),
        .cmdq_overflow       (cmdq_overflow),
        .cmdq_usedw          (cmdq_usedw),
        .cmdq_zero_len_drops (cmdq_zero_len_drops)
`ifdef DMA_CMDQ_HIGHWATER_EN
        ,
        .cmdq_usedw_highwater (cmdq_usedw_highwater)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    dma_cmd_t m_q[$];
    bit       m_under;
    bit       m_over;
    int       m_drops;
    int       m_hw;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic dma_cmd_t mk_cmd(input logic [39:0] len);
        dma_cmd_t c;
        c.src_start_addr = 48'({$urandom(), $urandom()});
        c.dst_start_addr = 48'({$urandom(), $urandom()});
        c.xfer_length    = len;
        return c;
    endfunction

    function automatic logic [39:0] rand_len();
        logic [39:0] l;
        l = {8'($urandom()), $urandom()};
        if (l == 40'd0) l = 40'd1;
        return l;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_under = 1'b0;
        m_over  = 1'b0;
        m_drops = 0;
        m_hw    = 0;
    endtask

    // One clock edge of the reference: applies the queue rules to the inputs
    // present at that edge.
    task automatic model_edge(input bit nc, input dma_cmd_t c, input bit pop, input bit clr);
        int  sz;
        bit  popped;
        sz = m_q.size();
        if (clr) begin
            model_reset();
        end else begin
            if (sz > m_hw) m_hw = sz;
            popped = pop && (sz > 0);
            if (pop && sz == 0) m_under = 1'b1;
            if (popped) void'(m_q.pop_front());
            if (nc) begin
                if (c.xfer_length == 40'd0) begin
                    if (m_drops < 65535) m_drops++;
                end else if (sz < DEPTH || popped) begin
                    m_q.push_back(c);
                end else begin
                    m_over = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string ctx);
        int sz;
        sz = m_q.size();
        check_eq({ctx, ".usedw"},     256'(cmdq_usedw), 256'(sz));
        check_eq({ctx, ".empty"},     256'(cmdq_empty), 256'(sz == 0));
        check_eq({ctx, ".full"},      256'(cmdq_full), 256'(sz == DEPTH));
        check_eq({ctx, ".valid"},     256'(cmd_if.cmd_valid), 256'(sz != 0));
        check_eq({ctx, ".underflow"}, 256'(cmdq_underflow), 256'(m_under));
        check_eq({ctx, ".overflow"},  256'(cmdq_overflow), 256'(m_over));
        check_eq({ctx, ".zdrops"},    256'(cmdq_zero_len_drops), 256'(m_drops));
        if (sz > 0) check_eq({ctx, ".cmd_out"}, 256'(cmd_if.cmd_out), 256'(m_q[0]));
`ifdef DMA_CMDQ_HIGHWATER_EN
        check_eq({ctx, ".highwater"}, 256'(cmdq_usedw_highwater), 256'(m_hw));
`endif
    endtask

    // Drive one cycle's inputs, advance an edge, update the model, then check.
    task automatic cyc(input string ctx, input bit nc, input dma_cmd_t c, input bit pop, input bit clr);
        cmd_if.new_cmd = nc;
        cmd_if.cmd_in  = c;
        cmd_if.cmd_pop = pop;
        sclr           = clr;
        @(posedge clk);
        model_edge(nc, c, pop, clr);
        #1;
        check_all(ctx);
    endtask

    task automatic idle(input string ctx);
        cyc(ctx, 1'b0, mk_cmd(40'd1), 1'b0, 1'b0);
    endtask

    initial begin
        dma_cmd_t c;
        model_reset();
        resetn         = 1'b0;
        sclr           = 1'b0;
        cmd_if.new_cmd = 1'b0;
        cmd_if.cmd_pop = 1'b0;
        cmd_if.cmd_in  = '0;
        #12;
        check_all("reset");
        resetn = 1'b1;
        @(posedge clk); #1;

        // Three pushes, then three pops in order.
        cyc("push64", 1'b1, mk_cmd(40'd64), 1'b0, 1'b0);
        check_eq("first_len", 256'(cmd_if.cmd_out[39:0]), 256'(64));
        cyc("push128", 1'b1, mk_cmd(40'd128), 1'b0, 1'b0);
        cyc("push4096", 1'b1, mk_cmd(40'd4096), 1'b0, 1'b0);
        check_eq("usedw3", 256'(cmdq_usedw), 256'(3));
        check_eq("pre_pop_len", 256'(cmd_if.cmd_out[39:0]), 256'(64));
        cyc("pop1", 1'b0, mk_cmd(40'd1), 1'b1, 1'b0);
        check_eq("pop1_len", 256'(cmd_if.cmd_out[39:0]), 256'(128));
        cyc("pop2", 1'b0, mk_cmd(40'd1), 1'b1, 1'b0);
        check_eq("pop2_len", 256'(cmd_if.cmd_out[39:0]), 256'(4096));
        cyc("pop3", 1'b0, mk_cmd(40'd1), 1'b1, 1'b0);
        check_eq("empty_after3", 256'(cmdq_empty), 256'(1));

        // Fill, push+pop at full, overflow push, drain.
        for (int i = 0; i < DEPTH; i++) cyc("fill", 1'b1, mk_cmd(rand_len()), 1'b0, 1'b0);
        check_eq("full_at_depth", 256'(cmdq_full), 256'(1));
        cyc("full_pushpop", 1'b1, mk_cmd(40'h00_1234_5678), 1'b1, 1'b0);
        check_eq("pushpop_no_ovf", 256'(cmdq_overflow), 256'(0));
        cyc("ovf_push", 1'b1, mk_cmd(40'hAB_CDEF_0123), 1'b0, 1'b0);
        check_eq("ovf_set", 256'(cmdq_overflow), 256'(1));
        check_eq("ovf_usedw", 256'(cmdq_usedw), 256'(DEPTH));
        for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b0, mk_cmd(40'd1), 1'b1, 1'b0);

        // Pop while empty, then clear.
        cyc("pop_empty", 1'b0, mk_cmd(40'd1), 1'b1, 1'b0);
        check_eq("underflow_set", 256'(cmdq_underflow), 256'(1));
        cyc("push_after_uf", 1'b1, mk_cmd(40'd77), 1'b0, 1'b0);
        cyc("sclr1", 1'b0, mk_cmd(40'd1), 1'b0, 1'b1);
        check_eq("underflow_clr", 256'(cmdq_underflow), 256'(0));

        // Zero-length discard.
        cyc("zero_len", 1'b1, mk_cmd(40'd0), 1'b0, 1'b0);
        check_eq("zdrop_one", 256'(cmdq_zero_len_drops), 256'(1));

        // sclr overrides a same-cycle push.
        for (int i = 0; i < 5; i++) cyc("five", 1'b1, mk_cmd(rand_len()), 1'b0, 1'b0);
        cyc("sclr_push", 1'b1, mk_cmd(40'd99), 1'b0, 1'b1);
        check_eq("sclr_usedw", 256'(cmdq_usedw), 256'(0));

        // Push 10, pop 10 (peak occupancy 10).
        for (int i = 0; i < 10; i++) cyc("hw_push", 1'b1, mk_cmd(rand_len()), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc("hw_pop", 1'b0, mk_cmd(40'd1), 1'b1, 1'b0);
        idle("hw_settle");
`ifdef DMA_CMDQ_HIGHWATER_EN
        check_eq("highwater10", 256'(cmdq_usedw_highwater), 256'(10));
`endif

        // Randomized traffic: a filling phase then a draining-biased phase.
        for (int i = 0; i < 3000; i++) begin
            bit nc, pop, clr;
            int ppct;
            ppct = (i < 1500) ? 25 : 60;
            nc   = ($urandom_range(0, 99) < 60);
            pop  = ($urandom_range(0, 99) < ppct);
            clr  = ($urandom_range(0, 999) < 2);
            c    = mk_cmd(($urandom_range(0, 9) == 0) ? 40'd0 : rand_len());
            cyc("rand", nc, c, pop, clr);
        end

        // Asynchronous reset mid-cycle with entries queued.
        for (int i = 0; i < 4; i++) cyc("pre_arst", 1'b1, mk_cmd(rand_len()), 1'b0, 1'b0);
        cyc("pre_arst_uf", 1'b0, mk_cmd(40'd1), 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        idle("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
